// File: rtl/video_timing_scaled.sv
// Parametrised raster timing generator with a downscaled lookahead coordinate
// stream so a pipelined renderer's pixels land on the cycle ad_out is high.
module video_timing_scaled #(
  parameter int unsigned ACTIVE_H   = 1280,
  parameter int unsigned FP_H       = 110,
  parameter int unsigned SYNC_H     = 40,
  parameter int unsigned BP_H       = 220,
  parameter int unsigned ACTIVE_V   = 720,
  parameter int unsigned FP_V       = 5,
  parameter int unsigned SYNC_V     = 5,
  parameter int unsigned BP_V       = 20,
  parameter int unsigned FPS        = 60,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned LOOKAHEAD  = 2,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1
) (
  input  logic                                                          clk_pixel_in,
  input  logic                                                          rst_in,
  input  logic                                                          en_in,
  output logic [$clog2(ACTIVE_H+FP_H+SYNC_H+BP_H)-1:0]                  hcount_out,
  output logic [$clog2(ACTIVE_V+FP_V+SYNC_V+BP_V)-1:0]                  vcount_out,
  output logic                                                          hs_out,
  output logic                                                          vs_out,
  output logic                                                          ad_out,
  output logic                                                          nf_out,
  output logic [$clog2(FPS)-1:0]                                        fc_out,
  output logic [$clog2(ACTIVE_H+FP_H+SYNC_H+BP_H)-SCALE_LOG2-1:0]       sx_out,
  output logic [$clog2(ACTIVE_V+FP_V+SYNC_V+BP_V)-SCALE_LOG2-1:0]       sy_out,
  output logic                                                          fetch_valid_out
);

  localparam int unsigned TOTAL_H = ACTIVE_H + FP_H + SYNC_H + BP_H;
  localparam int unsigned TOTAL_V = ACTIVE_V + FP_V + SYNC_V + BP_V;
  localparam int unsigned HW      = $clog2(TOTAL_H);
  localparam int unsigned VW      = $clog2(TOTAL_V);
  localparam int unsigned FW      = $clog2(FPS);
  localparam int unsigned SXW     = HW - SCALE_LOG2;
  localparam int unsigned SYW     = VW - SCALE_LOG2;

  localparam logic [HW-1:0] H_LAST = HW'(TOTAL_H - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(ACTIVE_H);
  localparam logic [HW-1:0] HS_BEG = HW'(ACTIVE_H + FP_H);
  localparam logic [HW-1:0] HS_END = HW'(ACTIVE_H + FP_H + SYNC_H);
  localparam logic [HW-1:0] LA_H0  = HW'(LOOKAHEAD - 1);
  localparam logic [VW-1:0] V_LAST = VW'(TOTAL_V - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(ACTIVE_V);
  localparam logic [VW-1:0] VS_BEG = VW'(ACTIVE_V + FP_V);
  localparam logic [VW-1:0] VS_END = VW'(ACTIVE_V + FP_V + SYNC_V);
  localparam logic [FW-1:0] FC_LAST = FW'(FPS - 1);

  logic [HW-1:0] hl;
  logic [VW-1:0] vl;
  logic [HW-1:0] h_nx;
  logic [VW-1:0] v_nx;
  logic [HW-1:0] hl_nx;
  logic [VW-1:0] vl_nx;
  logic          la_valid;
  logic          nf_nx;
  logic [FW-1:0] fc_nx;

  // Next raster positions for the display counter and the lookahead counter
  always_comb begin
    h_nx  = hcount_out + 1'b1;
    v_nx  = vcount_out;
    hl_nx = hl + 1'b1;
    vl_nx = vl;
    if (hcount_out == H_LAST) begin
      h_nx = '0;
      v_nx = (vcount_out == V_LAST) ? '0 : vcount_out + 1'b1;
    end
    if (hl == H_LAST) begin
      hl_nx = '0;
      vl_nx = (vl == V_LAST) ? '0 : vl + 1'b1;
    end
    la_valid = (hl_nx < H_ACT) && (vl_nx < V_ACT);
    nf_nx    = (h_nx == H_ACT) && (v_nx == V_ACT);
    fc_nx    = fc_out;
    if (nf_nx) begin
      fc_nx = (fc_out == FC_LAST) ? '0 : fc_out + 1'b1;
    end
  end

  // Every output is registered from the next position, so all stay aligned
  always_ff @(posedge clk_pixel_in or negedge rst_in) begin
    if (!rst_in) begin
      hcount_out      <= H_LAST;
      vcount_out      <= V_LAST;
      hl              <= LA_H0;
      vl              <= '0;
      hs_out          <= ~HS_POL;
      vs_out          <= ~VS_POL;
      ad_out          <= 1'b0;
      nf_out          <= 1'b0;
      fc_out          <= '0;
      sx_out          <= '0;
      sy_out          <= '0;
      fetch_valid_out <= 1'b0;
    end else if (en_in) begin
      hcount_out      <= h_nx;
      vcount_out      <= v_nx;
      hl              <= hl_nx;
      vl              <= vl_nx;
      hs_out          <= ((h_nx >= HS_BEG) && (h_nx < HS_END)) ? HS_POL : ~HS_POL;
      vs_out          <= ((v_nx >= VS_BEG) && (v_nx < VS_END)) ? VS_POL : ~VS_POL;
      ad_out          <= (h_nx < H_ACT) && (v_nx < V_ACT);
      nf_out          <= nf_nx;
      fc_out          <= fc_nx;
      sx_out          <= la_valid ? SXW'(hl_nx >> SCALE_LOG2) : '0;
      sy_out          <= la_valid ? SYW'(vl_nx >> SCALE_LOG2) : '0;
      fetch_valid_out <= la_valid;
    end else begin
      // A frozen cycle must not repeat the new-frame pulse
      nf_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_scaled.sv
// Bench for video_timing_scaled: a 720p instance checked against a table and a
// linear-pixel-index model, plus a tiny instance for frame-level and reset cases.
module tb_video_timing_scaled;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [31:0] fc;
    logic [31:0] sx;
    logic [31:0] sy;
    logic        fv;
  } obs_t;

  typedef struct {
    int ah; int fph; int syh; int bph;
    int av; int fpv; int syv; int bpv;
    int fps; int sc; int la;
    bit hp; bit vp;
  } cfg_t;

  typedef struct {
    int h; int v;
    bit ad; bit hs; bit fv;
    int sx; int sy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        b_rst, b_en;
  logic [10:0] b_h;
  logic [9:0]  b_v;
  logic        b_hs, b_vs, b_ad, b_nf, b_fv;
  logic [5:0]  b_fc;
  logic [8:0]  b_sx;
  logic [7:0]  b_sy;

  logic        s_rst, s_en;
  logic [3:0]  s_h;
  logic [2:0]  s_v;
  logic        s_hs, s_vs, s_ad, s_nf, s_fv;
  logic [1:0]  s_fc;
  logic [1:0]  s_sx;
  logic [0:0]  s_sy;

  video_timing_scaled dut_big (
    .clk_pixel_in(clk), .rst_in(b_rst), .en_in(b_en),
    .hcount_out(b_h), .vcount_out(b_v), .hs_out(b_hs), .vs_out(b_vs),
    .ad_out(b_ad), .nf_out(b_nf), .fc_out(b_fc), .sx_out(b_sx), .sy_out(b_sy),
    .fetch_valid_out(b_fv)
  );

  video_timing_scaled #(
    .ACTIVE_H(8), .FP_H(1), .SYNC_H(2), .BP_H(1),
    .ACTIVE_V(4), .FP_V(1), .SYNC_V(2), .BP_V(1), .FPS(3)
  ) dut_small (
    .clk_pixel_in(clk), .rst_in(s_rst), .en_in(s_en),
    .hcount_out(s_h), .vcount_out(s_v), .hs_out(s_hs), .vs_out(s_vs),
    .ad_out(s_ad), .nf_out(s_nf), .fc_out(s_fc), .sx_out(s_sx), .sy_out(s_sy),
    .fetch_valid_out(s_fv)
  );

  int n_tests = 0;
  int n_fail  = 0;

  cfg_t bc, sc;
  vec_t tbl [17];

  // Expected outputs when the display sits at linear pixel index p of the frame
  function automatic obs_t model_obs(cfg_t c, int p, int fc, bit nf, bit fresh);
    obs_t o;
    int th, tv, n, h, v, q, hl, vl;
    bit fv;
    th = c.ah + c.fph + c.syh + c.bph;
    tv = c.av + c.fpv + c.syv + c.bpv;
    n  = th * tv;
    h  = p % th;
    v  = p / th;
    q  = (p + c.la) % n;
    hl = q % th;
    vl = q / th;
    fv = (hl < c.ah) && (vl < c.av);
    o.h  = h;
    o.v  = v;
    o.hs = ((h >= c.ah + c.fph) && (h < c.ah + c.fph + c.syh)) ? c.hp : !c.hp;
    o.vs = ((v >= c.av + c.fpv) && (v < c.av + c.fpv + c.syv)) ? c.vp : !c.vp;
    o.ad = (h < c.ah) && (v < c.av);
    o.nf = nf;
    o.fc = fc;
    o.fv = fv && !fresh;
    o.sx = (fv && !fresh) ? (hl >> c.sc) : 0;
    o.sy = (fv && !fresh) ? (vl >> c.sc) : 0;
    return o;
  endfunction

  task automatic model_step(input cfg_t c, input bit en, inout int p, inout int fc,
                            inout bit nf, inout bit fresh);
    int th, n;
    th = c.ah + c.fph + c.syh + c.bph;
    n  = th * (c.av + c.fpv + c.syv + c.bpv);
    if (en) begin
      p     = (p + 1) % n;
      fresh = 1'b0;
      nf    = (p == c.av * th + c.ah);
      if (nf) fc = (fc + 1) % c.fps;
    end else begin
      nf = 1'b0;
    end
  endtask

  function automatic obs_t get_big();
    obs_t o;
    o.h = 32'(b_h); o.v = 32'(b_v); o.hs = b_hs; o.vs = b_vs; o.ad = b_ad; o.nf = b_nf;
    o.fc = 32'(b_fc); o.sx = 32'(b_sx); o.sy = 32'(b_sy); o.fv = b_fv;
    return o;
  endfunction

  function automatic obs_t get_small();
    obs_t o;
    o.h = 32'(s_h); o.v = 32'(s_v); o.hs = s_hs; o.vs = s_vs; o.ad = s_ad; o.nf = s_nf;
    o.fc = 32'(s_fc); o.sx = 32'(s_sx); o.sy = 32'(s_sy); o.fv = s_fv;
    return o;
  endfunction

  task automatic check(input string name, input obs_t a, input obs_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got h=%0d v=%0d hs=%0d vs=%0d ad=%0d nf=%0d fc=%0d sx=%0d sy=%0d fv=%0d | want h=%0d v=%0d hs=%0d vs=%0d ad=%0d nf=%0d fc=%0d sx=%0d sy=%0d fv=%0d",
               name, a.h, a.v, a.hs, a.vs, a.ad, a.nf, a.fc, a.sx, a.sy, a.fv,
               e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.fc, e.sx, e.sy, e.fv);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, a, e);
    end
  endtask

  initial begin
    int cur, tgt, bp, bfc, sp, sfc, pulses, dut_pulses;
    bit bnf, bfresh, snf, sfresh;
    obs_t e;

    bc = '{ah:1280, fph:110, syh:40, bph:220, av:720, fpv:5, syv:5, bpv:20,
           fps:60, sc:2, la:2, hp:1'b1, vp:1'b1};
    sc = '{ah:8, fph:1, syh:2, bph:1, av:4, fpv:1, syv:2, bpv:1,
           fps:3, sc:2, la:2, hp:1'b1, vp:1'b1};

    // {h, v} visited with en=1 -> {ad, hs, fetch_valid, sx, sy}; vs/nf/fc stay 0
    tbl = '{
      '{0,    0, 1, 0, 1, 0,   0},
      '{1,    0, 1, 0, 1, 0,   0},
      '{2,    0, 1, 0, 1, 1,   0},
      '{1277, 0, 1, 0, 1, 319, 0},
      '{1278, 0, 1, 0, 0, 0,   0},
      '{1279, 0, 1, 0, 0, 0,   0},
      '{1280, 0, 0, 0, 0, 0,   0},
      '{1389, 0, 0, 0, 0, 0,   0},
      '{1390, 0, 0, 1, 0, 0,   0},
      '{1429, 0, 0, 1, 0, 0,   0},
      '{1430, 0, 0, 0, 0, 0,   0},
      '{1648, 0, 0, 0, 1, 0,   0},
      '{1649, 0, 0, 0, 1, 0,   0},
      '{0,    1, 1, 0, 1, 0,   0},
      '{1648, 4, 0, 0, 1, 0,   1},
      '{1277, 5, 1, 0, 1, 319, 1},
      '{1278, 5, 1, 0, 0, 0,   0}
    };

    b_rst = 1'b0; b_en = 1'b0; s_rst = 1'b0; s_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("big_reset", get_big(), model_obs(bc, 1650 * 750 - 1, 0, 1'b0, 1'b1));

    b_rst = 1'b1; b_en = 1'b1;
    cur = -1;
    for (int i = 0; i < 17; i++) begin
      tgt = tbl[i].v * 1650 + tbl[i].h;
      repeat (tgt - cur) @(posedge clk);
      #1;
      cur = tgt;
      e.h = tbl[i].h; e.v = tbl[i].v; e.hs = tbl[i].hs; e.vs = 1'b0;
      e.ad = tbl[i].ad; e.nf = 1'b0; e.fc = 0;
      e.sx = tbl[i].sx; e.sy = tbl[i].sy; e.fv = tbl[i].fv;
      check($sformatf("tbl_%0d_%0d", tbl[i].h, tbl[i].v), get_big(), e);
    end

    // Random enable on the 720p instance
    bp = cur; bfc = 0; bnf = 1'b0; bfresh = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      b_en = ($urandom_range(3) != 0);
      @(posedge clk);
      model_step(bc, b_en, bp, bfc, bnf, bfresh);
      #1;
      check("big_rand", get_big(), model_obs(bc, bp, bfc, bnf, bfresh));
    end
    b_en = 1'b0;

    // Small instance: reset state, then 61 frames under random enable
    check("small_reset", get_small(), model_obs(sc, 95, 0, 1'b0, 1'b1));
    sp = 95; sfc = 0; snf = 1'b0; sfresh = 1'b1;
    s_rst = 1'b1;
    pulses = 0; dut_pulses = 0;
    for (int cyc = 0; cyc < 30000 && pulses < 61; cyc++) begin
      s_en = ($urandom_range(3) != 0);
      @(posedge clk);
      model_step(sc, s_en, sp, sfc, snf, sfresh);
      #1;
      if (snf) pulses++;
      if (s_nf) dut_pulses++;
      check("small_run", get_small(), model_obs(sc, sp, sfc, snf, sfresh));
    end
    check_int("nf_pulses_61", dut_pulses, 61);
    check_int("fc_after_61", 32'(s_fc), 61 % 3);

    // Freeze one pixel before the new-frame point, then resume
    for (int k = 0; k < 200 && sp != 4 * 12 + 7; k++) begin
      s_en = 1'b1;
      @(posedge clk);
      model_step(sc, s_en, sp, sfc, snf, sfresh);
      #1;
      check("to_hold", get_small(), model_obs(sc, sp, sfc, snf, sfresh));
    end
    check_int("hold_pos", sp, 55);
    s_en = 1'b0;
    repeat (10) begin
      @(posedge clk);
      model_step(sc, s_en, sp, sfc, snf, sfresh);
      #1;
      check("hold", get_small(), model_obs(sc, sp, sfc, snf, sfresh));
    end
    s_en = 1'b1;
    @(posedge clk);
    model_step(sc, s_en, sp, sfc, snf, sfresh);
    #1;
    check("resume", get_small(), model_obs(sc, sp, sfc, snf, sfresh));
    check_int("resume_nf", 32'(s_nf), 1);
    check_int("resume_h", 32'(s_h), 8);
    @(posedge clk);
    model_step(sc, s_en, sp, sfc, snf, sfresh);
    #1;
    check_int("nf_once", 32'(s_nf), 0);

    // Asynchronous reset in the middle of a frame at (5,2)
    for (int k = 0; k < 200 && sp != 2 * 12 + 5; k++) begin
      @(posedge clk);
      model_step(sc, s_en, sp, sfc, snf, sfresh);
      #1;
    end
    #2;
    s_rst = 1'b0;
    #1;
    sp = 95; sfc = 0; snf = 1'b0; sfresh = 1'b1;
    check("async_rst", get_small(), model_obs(sc, sp, sfc, snf, sfresh));
    @(posedge clk);
    #1;
    check("rst_held", get_small(), model_obs(sc, sp, sfc, snf, sfresh));
    s_rst = 1'b1; s_en = 1'b1;
    @(posedge clk);
    model_step(sc, s_en, sp, sfc, snf, sfresh);
    #1;
    e.h = 0; e.v = 0; e.hs = 1'b0; e.vs = 1'b0; e.ad = 1'b1; e.nf = 1'b0; e.fc = 0;
    e.sx = 0; e.sy = 0; e.fv = 1'b1;
    check("post_rst_first", get_small(), e);
    for (int i = 0; i < 40; i++) begin
      s_en = ($urandom_range(1) != 0);
      @(posedge clk);
      model_step(sc, s_en, sp, sfc, snf, sfresh);
      #1;
      check("post_rst_run", get_small(), model_obs(sc, sp, sfc, snf, sfresh));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
